// File: rtl/door_pkg.sv
// Shared constants, state encoding and helpers for the keypad front end and
// the door controller.
package door_pkg;

  localparam int N_BTN = 4;

  localparam int BTN_0 = 0;
  localparam int BTN_1 = 1;
  localparam int BTN_2 = 2;
  localparam int BTN_3 = 3;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 8;
  localparam int STUCK_CYCLES_DEFAULT    = 1000;

  typedef enum logic {
    BTN_IDLE = 1'b0,
    BTN_HELD = 1'b1
  } btn_state_t;

  function automatic int unsigned count_ones(input logic [N_BTN-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < N_BTN; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Keypad bundle between the raw button source and the conditioner.
interface btn_conditioner_if
  import door_pkg::*;
#(
  parameter int N = N_BTN
);
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn;
  logic         multi_press;
  logic         stuck;
  logic         idle;

  modport master (output btn_raw, input btn, multi_press, stuck, idle);
  modport slave  (input btn_raw, output btn, multi_press, stuck, idle);
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser followed by a restart-on-bounce debounce
// counter that owns the debounced level.
module btn_debounce
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_reg;
  logic          s2_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      s1_reg <= raw;
      s2_reg <= s1_reg;
      // Any sample agreeing with the current level restarts the count.
      if (s2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        level_reg <= ~level_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
endmodule

// File: rtl/btn_conditioner.sv
// Debounced keypad front end: one-hot single-cycle press pulses, one key at
// a time, with simultaneous-press and stuck-key flags.
module btn_conditioner
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  btn_conditioner_if.slave bus
);
  localparam logic [15:0] STUCK_LIMIT = 16'(STUCK_CYCLES);

  logic [N_BTN-1:0] deb;
  logic [N_BTN-1:0] deb_d_reg;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] btn_reg;
  logic [N_BTN-1:0] btn_next;
  logic             multi_reg;
  logic             multi_next;
  logic [15:0]      stuck_cnt_reg;
  btn_state_t       state_reg;
  btn_state_t       state_next;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (bus.btn_raw[gi]),
      .level(deb[gi])
    );
  end

  assign rise = deb & ~deb_d_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= BTN_IDLE;
      deb_d_reg     <= '0;
      btn_reg       <= '0;
      multi_reg     <= 1'b0;
      stuck_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      deb_d_reg <= deb;
      btn_reg   <= btn_next;
      multi_reg <= multi_next;
      if (deb == '0) begin
        stuck_cnt_reg <= '0;
      end else if (stuck_cnt_reg != 16'hFFFF) begin
        stuck_cnt_reg <= stuck_cnt_reg + 16'd1;
      end
    end
  end

  // Once anything is accepted, further rises are locked out until every
  // debounced key is back at zero.
  always_comb begin
    state_next = state_reg;
    btn_next   = '0;
    multi_next = 1'b0;
    case (state_reg)
      BTN_IDLE: begin
        if (count_ones(rise) == 1) begin
          btn_next   = rise;
          state_next = BTN_HELD;
        end else if (count_ones(rise) >= 2) begin
          multi_next = 1'b1;
          state_next = BTN_HELD;
        end
      end
      BTN_HELD: begin
        if (deb == '0) state_next = BTN_IDLE;
      end
      default: state_next = BTN_IDLE;
    endcase
  end

  assign bus.btn         = btn_reg;
  assign bus.multi_press = multi_reg;
  assign bus.stuck       = (stuck_cnt_reg >= STUCK_LIMIT);
  assign bus.idle        = (state_reg == BTN_IDLE) && (deb == '0);
endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (DEBOUNCE_CYCLES = 8, STUCK_CYCLES = 50).
// Edge e of each loop is the first edge that samples the value driven in it.
module tb_btn_conditioner;
  import door_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  btn_conditioner_if bus_if ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .STUCK_CYCLES   (50)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_all(input int n);
    for (int e = 0; e < n; e++) begin
      bus_if.btn_raw = 4'b0000;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus_if.btn_raw = 4'b0101;
    for (int e = 0; e < 3; e++) tick();
    total += 4;
    if (bus_if.btn !== 4'b0000) begin
      bad++; $display("FAIL reset_btn got=%b want=0000", bus_if.btn);
    end
    if (bus_if.multi_press !== 1'b0) begin
      bad++; $display("FAIL reset_multi got=%b want=0", bus_if.multi_press);
    end
    if (bus_if.stuck !== 1'b0) begin
      bad++; $display("FAIL reset_stuck got=%b want=0", bus_if.stuck);
    end
    if (bus_if.idle !== 1'b1) begin
      bad++; $display("FAIL reset_idle got=%b want=1", bus_if.idle);
    end
    bus_if.btn_raw = 4'b0000;
    tick();
    reset = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      total++;
      if (bus_if.btn !== 4'b0000 || bus_if.multi_press !== 1'b0) begin
        bad++;
        $display("FAIL reset_nopulse e=%0d got btn=%b multi=%b want 0000/0",
                 e, bus_if.btn, bus_if.multi_press);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_btn;
    logic       exp_idle;
    for (int e = 0; e < 20; e++) begin
      bus_if.btn_raw = 4'b0001;
      tick();
      exp_btn  = (e == 10) ? 4'b0001 : 4'b0000;
      exp_idle = (e < 9);
      total += 2;
      if (bus_if.btn !== exp_btn) begin
        bad++; $display("FAIL single_btn e=%0d got=%b want=%b", e, bus_if.btn, exp_btn);
      end
      if (bus_if.idle !== exp_idle) begin
        bad++; $display("FAIL single_idle e=%0d got=%b want=%b", e, bus_if.idle, exp_idle);
      end
    end
    for (int e = 0; e < 15; e++) begin
      bus_if.btn_raw = 4'b0000;
      tick();
      exp_idle = (e >= 10);
      total++;
      if (bus_if.idle !== exp_idle) begin
        bad++; $display("FAIL single_release_idle e=%0d got=%b want=%b", e, bus_if.idle, exp_idle);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_btn;
    for (int e = 0; e < 50; e++) begin
      if (e < 30) bus_if.btn_raw = (((e / 3) % 2) == 0) ? 4'b0100 : 4'b0000;
      else        bus_if.btn_raw = 4'b0100;
      tick();
      exp_btn = (e == 40) ? 4'b0100 : 4'b0000;
      total++;
      if (bus_if.btn !== exp_btn) begin
        bad++; $display("FAIL bounce_btn e=%0d got=%b want=%b", e, bus_if.btn, exp_btn);
      end
    end
    release_all(15);
  endtask

  task automatic test_multi();
    logic [3:0] exp_btn;
    logic       exp_multi;
    for (int e = 0; e < 20; e++) begin
      bus_if.btn_raw = 4'b1010;
      tick();
      exp_multi = (e == 10);
      total += 2;
      if (bus_if.btn !== 4'b0000) begin
        bad++; $display("FAIL multi_btn e=%0d got=%b want=0000", e, bus_if.btn);
      end
      if (bus_if.multi_press !== exp_multi) begin
        bad++; $display("FAIL multi_pulse e=%0d got=%b want=%b", e, bus_if.multi_press, exp_multi);
      end
      if (e == 12) begin
        total++;
        if (bus_if.idle !== 1'b0) begin
          bad++; $display("FAIL multi_idle_held got=%b want=0", bus_if.idle);
        end
      end
    end
    release_all(15);
    total++;
    if (bus_if.idle !== 1'b1) begin
      bad++; $display("FAIL multi_idle_released got=%b want=1", bus_if.idle);
    end
    for (int e = 0; e < 12; e++) begin
      bus_if.btn_raw = 4'b0010;
      tick();
      exp_btn = (e == 10) ? 4'b0010 : 4'b0000;
      total++;
      if (bus_if.btn !== exp_btn) begin
        bad++; $display("FAIL multi_after_btn e=%0d got=%b want=%b", e, bus_if.btn, exp_btn);
      end
    end
    release_all(15);
  endtask

  task automatic test_lockout();
    logic [3:0] exp_btn;
    for (int e = 0; e < 25; e++) begin
      bus_if.btn_raw = (e < 5) ? 4'b0001 : 4'b1001;
      tick();
      exp_btn = (e == 10) ? 4'b0001 : 4'b0000;
      total++;
      if (bus_if.btn !== exp_btn) begin
        bad++; $display("FAIL lockout_btn e=%0d got=%b want=%b", e, bus_if.btn, exp_btn);
      end
    end
    for (int e = 0; e < 15; e++) begin
      bus_if.btn_raw = 4'b1000;
      tick();
      total++;
      if (bus_if.btn !== 4'b0000) begin
        bad++; $display("FAIL lockout_release0 e=%0d got=%b want=0000", e, bus_if.btn);
      end
    end
    release_all(15);
    for (int e = 0; e < 12; e++) begin
      bus_if.btn_raw = 4'b1000;
      tick();
      exp_btn = (e == 10) ? 4'b1000 : 4'b0000;
      total++;
      if (bus_if.btn !== exp_btn) begin
        bad++; $display("FAIL lockout_repress e=%0d got=%b want=%b", e, bus_if.btn, exp_btn);
      end
    end
    release_all(15);
  endtask

  task automatic test_stuck();
    logic exp_stuck;
    for (int e = 0; e < 80; e++) begin
      bus_if.btn_raw = 4'b0010;
      tick();
      exp_stuck = (e >= 59);
      total++;
      if (bus_if.stuck !== exp_stuck) begin
        bad++; $display("FAIL stuck_hold e=%0d got=%b want=%b", e, bus_if.stuck, exp_stuck);
      end
    end
    for (int e = 0; e < 15; e++) begin
      bus_if.btn_raw = 4'b0000;
      tick();
      exp_stuck = (e < 10);
      total++;
      if (bus_if.stuck !== exp_stuck) begin
        bad++; $display("FAIL stuck_release e=%0d got=%b want=%b", e, bus_if.stuck, exp_stuck);
      end
    end
    for (int e = 0; e < 70; e++) begin
      bus_if.btn_raw = 4'b0010;
      tick();
    end
    total++;
    if (bus_if.stuck !== 1'b1) begin
      bad++; $display("FAIL stuck_rehold got=%b want=1", bus_if.stuck);
    end
    reset = 1'b0;
    tick();
    total += 3;
    if (bus_if.stuck !== 1'b0) begin
      bad++; $display("FAIL stuck_reset got=%b want=0", bus_if.stuck);
    end
    if (bus_if.idle !== 1'b1) begin
      bad++; $display("FAIL stuck_reset_idle got=%b want=1", bus_if.idle);
    end
    if (bus_if.btn !== 4'b0000) begin
      bad++; $display("FAIL stuck_reset_btn got=%b want=0000", bus_if.btn);
    end
    bus_if.btn_raw = 4'b0000;
    reset = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      total++;
      if (bus_if.btn !== 4'b0000 || bus_if.stuck !== 1'b0) begin
        bad++;
        $display("FAIL stuck_post_reset e=%0d got btn=%b stuck=%b want 0000/0",
                 e, bus_if.btn, bus_if.stuck);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus_if.btn_raw = 4'b0000;
    test_reset();
    test_single();
    test_bounce();
    test_multi();
    test_lockout();
    test_stuck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
